// File: rtl/acc_bias_pkg.sv
// rtl/acc_bias_pkg.sv - shared state encoding and width/limit helpers for acc_bias_unit
package acc_bias_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // One guard bit above clog2 growth keeps the bias add from overflowing.
  function automatic int acc_width(input int m_bw, input int acc_len);
    return m_bw + $clog2(acc_len) + 1;
  endfunction

  function automatic longint sat_max(input int ab_bw);
    return (longint'(1) <<< (ab_bw - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int ab_bw);
    return -(longint'(1) <<< (ab_bw - 1));
  endfunction

endpackage

// File: rtl/acc_bias_sat.sv
// rtl/acc_bias_sat.sv - combinational ACC_W to AB_BW narrower, saturating when ACC_BIAS_SAT_EN is defined
module acc_bias_sat
  import acc_bias_pkg::*;
#(
  parameter int ACC_W = 21,
  parameter int AB_BW = 21
) (
  input  logic [ACC_W-1:0] acc,
  output logic [AB_BW-1:0] acc_narrow
);

  generate
    if (ACC_W <= AB_BW) begin : g_ext
      assign acc_narrow = AB_BW'($signed(acc));
    end else begin : g_narrow
`ifdef ACC_BIAS_SAT_EN
      localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(AB_BW));
      localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(AB_BW));
      always_comb begin
        acc_narrow = AB_BW'(acc);
        if ($signed(acc) > MAX_V) begin
          acc_narrow = AB_BW'(MAX_V);
        end else if ($signed(acc) < MIN_V) begin
          acc_narrow = AB_BW'(MIN_V);
        end
      end
`else
      assign acc_narrow = AB_BW'(acc);
`endif
    end
  endgenerate

endmodule

// File: rtl/acc_bias_unit.sv
// rtl/acc_bias_unit.sv - per-window product accumulator plus bias with valid/ready handshakes
// Define ACC_BIAS_SAT_EN for saturating output narrowing; otherwise the sum wraps.
module acc_bias_unit
  import acc_bias_pkg::*;
#(
  parameter int M_BW    = 16,
  parameter int B_BW    = 8,
  parameter int AB_BW   = 21,
  parameter int ACC_LEN = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_valid,
  output logic             o_ready_in,
  input  logic [M_BW-1:0]  i_mul_data,
  input  logic [B_BW-1:0]  i_bias,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [AB_BW-1:0] o_acc_bias
);

  localparam int ACC_W = acc_width(M_BW, ACC_LEN);
  localparam int CNT_W = $clog2(ACC_LEN + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc, acc_nxt, mul_ext, bias_ext;
  logic [AB_BW-1:0]  acc_narrow;
  logic              accept, start, last;

  assign mul_ext  = ACC_W'($signed(i_mul_data));
  assign bias_ext = ACC_W'($signed(i_bias));

  // A beat taken outside S_ACC (idle, or a handoff cycle in S_OUT) opens a new window.
  assign start   = (state != S_ACC);
  assign last    = start ? (ACC_LEN == 1) : (cnt == CNT_W'(ACC_LEN - 1));
  assign accept  = i_valid && o_ready_in;
  assign acc_nxt = start ? (mul_ext + bias_ext) : (acc + mul_ext);

  acc_bias_sat #(
    .ACC_W (ACC_W),
    .AB_BW (AB_BW)
  ) u_sat (
    .acc        (acc_nxt),
    .acc_narrow (acc_narrow)
  );

  always_comb begin
    state_nxt  = state;
    o_valid    = 1'b0;
    o_ready_in = 1'b1;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = last ? S_OUT : S_ACC;
      end
      S_ACC: begin
        if (accept && last) state_nxt = S_OUT;
      end
      S_OUT: begin
        o_valid    = 1'b1;
        o_ready_in = i_ready;
        if (i_ready) state_nxt = accept ? (last ? S_OUT : S_ACC) : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      acc        <= '0;
      o_acc_bias <= '0;
    end else if (i_clear) begin
      state <= S_IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc <= acc_nxt;
        cnt <= start ? CNT_W'(1) : cnt + CNT_W'(1);
        if (last) o_acc_bias <= acc_narrow;
      end
    end
  end

endmodule
